// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and constants for the iterative multiply/divide unit.
package mdu_pkg;

    // Register file data width; one iteration per result bit
    localparam int MDU_WIDTH = 16;
    localparam int ITERS     = MDU_WIDTH;

    // Operation encodings; bit 1 selects divide, bit 0 selects the upper half
    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // True for the two divide-family operations
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the multiply/divide datapath.
// Multiply: acc += mc when the current multiplier bit is set, then mc <<= 1,
//           mp >>= 1 (mp becomes zero once all set bits are consumed).
// Divide:   acc holds {remainder, dividend/quotient}; shift left by one,
//           trial-subtract the divisor (mp) from the upper half, and shift
//           a 1 into the quotient when no borrow occurs (restoring).
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITERS
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [2*WIDTH-1:0]   mc_i,
    input  logic [WIDTH-1:0]     mp_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [2*WIDTH-1:0]   mc_o,
    output logic [WIDTH-1:0]     mp_o
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   diff;

    // Select add-and-shift or trial-subtract for this iteration
    always_comb begin
        shifted = {acc_i, 1'b0};
        diff    = shifted[2*WIDTH:WIDTH] - {1'b0, mp_i};
        acc_o   = acc_i;
        mc_o    = mc_i;
        mp_o    = mp_i;
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_o = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = shifted[2*WIDTH-1:0];
            end
        end else begin
            acc_o = mp_i[0] ? (acc_i + mc_i) : acc_i;
            mc_o  = {mc_i[2*WIDTH-2:0], 1'b0};
            mp_o  = {1'b0, mp_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative 16-bit unsigned multiply/divide with start/busy/done
// handshake and register-file write-back (writes to r0 are suppressed).
// Build option: define MDU_EARLY_OUT_EN to let multiplies finish as soon as
// the remaining multiplier bits are zero (b==0 skips RUN entirely).
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = ITERS,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    dst,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr
);

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [1:0]           op_q;
    logic [AW-1:0]        dst_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   acc_q, mc_q;
    logic [WIDTH-1:0]     mp_q;
    logic [2*WIDTH-1:0]   acc_s, mc_s;
    logic [WIDTH-1:0]     mp_s;
    logic                 accept, finish, zero_skip;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_is_div(op_q)),
        .acc_i  (acc_q),
        .mc_i   (mc_q),
        .mp_i   (mp_q),
        .acc_o  (acc_s),
        .mc_o   (mc_s),
        .mp_o   (mp_s)
    );

    // State register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        finish    = 1'b0;
        zero_skip = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                    if (EARLY_OUT && !op_is_div(op) && b == '0) begin
                        zero_skip = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            RUN: begin
                if (cnt_q == LAST) finish = 1'b1;
                if (EARLY_OUT && !op_is_div(op_q) && mp_s == '0) finish = 1'b1;
                if (finish) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign wr_en = done && (wr_addr != '0);

    // Operand capture, per-cycle iteration, and result/address load on entry to DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q    <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            result  <= '0;
            wr_addr <= '0;
        end else if (accept) begin
            op_q  <= op;
            dst_q <= dst;
            cnt_q <= '0;
            mp_q  <= b;
            if (op_is_div(op)) begin
                acc_q <= {{WIDTH{1'b0}}, a};
                mc_q  <= '0;
            end else begin
                acc_q <= '0;
                mc_q  <= {{WIDTH{1'b0}}, a};
            end
            if (zero_skip) begin
                result  <= '0;
                wr_addr <= dst;
            end
        end else if (state_q == RUN) begin
            acc_q <= acc_s;
            mc_q  <= mc_s;
            mp_q  <= mp_s;
            cnt_q <= cnt_q + CW'(1);
            if (finish) begin
                result  <= op_q[0] ? acc_s[2*WIDTH-1:WIDTH] : acc_s[WIDTH-1:0];
                wr_addr <= dst_q;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter using an arithmetic reference
// model (native *, /, %) and a latency model derived from the operation rules.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [3:0]  dst;
    logic        busy, done, wr_en;
    logic [15:0] result;
    logic [3:0]  wr_addr;

    int total = 0;
    int bad   = 0;

    mdu_iter dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .dst     (dst),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .wr_en   (wr_en),
        .wr_addr (wr_addr)
    );

    always #5 clk = ~clk;

    // Reference result from plain arithmetic
    function automatic logic [15:0] ref_res(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        logic [31:0] p;
        p = 32'(x) * 32'(y);
        case (o)
            2'b00:   return p[15:0];
            2'b01:   return p[31:16];
            2'b10:   return (y == 16'd0) ? 16'hFFFF : x / y;
            default: return (y == 16'd0) ? x : x % y;
        endcase
    endfunction

    // Clock edges from the accepting edge up to and including the one that raises done
    function automatic int ref_lat(input logic [1:0] o, input logic [15:0] y);
        int msb;
`ifdef MDU_EARLY_OUT_EN
        if (!o[1]) begin
            if (y == 16'd0) return 1;
            msb = 0;
            for (int i = 0; i < 16; i++) if (y[i]) msb = i;
            return 2 + msb;
        end
`endif
        msb = 0;
        return 17 + msb;
    endfunction

    // Issue one op, scramble inputs after accept, wait (bounded) for done
    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                          input logic [3:0] d, output logic [15:0] res, output int lat,
                          output logic we, output logic [3:0] wa);
        @(negedge clk);
        op = o; a = x; b = y; dst = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); dst = 4'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result; we = wr_en; wa = wr_addr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; dst = '0;
        #12;
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%0h want=0", busy); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%0h want=0", done); end
        total++; if (wr_en !== 1'b0)   begin bad++; $display("FAIL reset_wr_en got=%0h want=0", wr_en); end
        total++; if (result !== 16'h0) begin bad++; $display("FAIL reset_result got=%0h want=0", result); end
        total++; if (wr_addr !== 4'h0) begin bad++; $display("FAIL reset_wr_addr got=%0h want=0", wr_addr); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  ops [10] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b00};
        logic [15:0] va  [10] = '{16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF, 16'd100, 16'd100, 16'h8000, 16'h00AB, 16'h00AB, 16'h0123};
        logic [15:0] vb  [10] = '{16'h0010, 16'h0010, 16'hFFFF, 16'hFFFF, 16'd7, 16'd7, 16'h0001, 16'h0000, 16'h0000, 16'h0003};
        logic [15:0] ve  [10] = '{16'h2340, 16'h0001, 16'h0001, 16'hFFFE, 16'h000E, 16'h0002, 16'h8000, 16'hFFFF, 16'h00AB, 16'h0369};
        logic [15:0] res;
        logic        we;
        logic [3:0]  wa;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], va[i], vb[i], 4'd3, res, lat, we, wa);
            total++; if (res !== ve[i]) begin bad++; $display("FAIL dir%0d_result got=%0h want=%0h", i, res, ve[i]); end
            total++; if (lat != ref_lat(ops[i], vb[i])) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, ref_lat(ops[i], vb[i])); end
            total++; if (we !== 1'b1) begin bad++; $display("FAIL dir%0d_wr_en got=%0h want=1", i, we); end
            total++; if (wa !== 4'd3) begin bad++; $display("FAIL dir%0d_wr_addr got=%0h want=3", i, wa); end
        end
        // Destination r0: done pulses, no write strobe
        run_op(2'b00, 16'h1234, 16'h0010, 4'd0, res, lat, we, wa);
        total++; if (lat != ref_lat(2'b00, 16'h0010)) begin bad++; $display("FAIL r0_done_latency got=%0d want=%0d", lat, ref_lat(2'b00, 16'h0010)); end
        total++; if (we !== 1'b0) begin bad++; $display("FAIL r0_wr_en got=%0h want=0", we); end
        total++; if (res !== 16'h2340) begin bad++; $display("FAIL r0_result got=%0h want=2340", res); end
        // Early-out extremes for multiply: zero multiplier and top-bit multiplier
        run_op(2'b01, 16'hBEEF, 16'h0000, 4'd9, res, lat, we, wa);
        total++; if (res !== 16'h0000 || lat != ref_lat(2'b01, 16'h0000)) begin bad++; $display("FAIL mulzero got=%0h/%0d want=0/%0d", res, lat, ref_lat(2'b01, 16'h0000)); end
        run_op(2'b01, 16'hBEEF, 16'h8000, 4'd9, res, lat, we, wa);
        total++; if (res !== 16'h5F77 || lat != 17) begin bad++; $display("FAIL multop got=%0h/%0d want=5f77/17", res, lat); end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [15:0] x, y, res;
        logic [3:0]  d, wa;
        logic        we;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom); x = 16'($urandom); d = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       y = 16'd0;
                1:       y = 16'($urandom_range(1, 15));
                default: y = 16'($urandom);
            endcase
            run_op(o, x, y, d, res, lat, we, wa);
            total++; if (res !== ref_res(o, x, y)) begin bad++; $display("FAIL rnd%0d_result op=%0d a=%0h b=%0h got=%0h want=%0h", i, o, x, y, res, ref_res(o, x, y)); end
            total++; if (lat != ref_lat(o, y)) begin bad++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, ref_lat(o, y)); end
            total++; if (we !== (d != 4'd0) || wa !== d) begin bad++; $display("FAIL rnd%0d_write got=%0h@%0h want=%0h@%0h", i, we, wa, (d != 4'd0), d); end
        end
    endtask

    task automatic test_ignore_start();
        int          ndone = 0;
        int          nbusy = 0;
        logic [15:0] res = '0;
        @(negedge clk);
        op = 2'b00; a = 16'h0101; b = 16'h0202; dst = 4'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 2'b10; a = 16'h7777; b = 16'h0003; dst = 4'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin ndone++; res = result; end
            if (busy === 1'b1) nbusy++;
            @(posedge clk); #1;
        end
        total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
        total++; if (res !== 16'h0402) begin bad++; $display("FAIL ignore_result got=%0h want=0402", res); end
        total++; if (nbusy != ref_lat(2'b00, 16'h0202) - 1 - 5) begin bad++; $display("FAIL ignore_busy_tail got=%0d want=%0d", nbusy, ref_lat(2'b00, 16'h0202) - 6); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          when [4];
        logic [15:0] rv [4];
        int          n = 0;
        int          nb = 0;
        @(negedge clk);
        op = 2'b10; a = 16'd1000; b = 16'd9; dst = 4'd7; start = 1'b1;
        for (int t = 1; t <= 70; t++) begin
            @(posedge clk); #1;
            if (busy === 1'b1) nb++;
            if (done === 1'b1 && n < 4) begin when[n] = t; rv[n] = result; n++; end
        end
        start = 1'b0;
        total++; if (n != 3) begin bad++; $display("FAIL b2b_done_count got=%0d want=3", n); end
        if (n >= 3) begin
            for (int k = 0; k < 3; k++) begin
                total++; if (rv[k] !== 16'd111) begin bad++; $display("FAIL b2b_result%0d got=%0h want=006f", k, rv[k]); end
            end
            total++; if (when[0] != 17 || when[1] - when[0] != 18 || when[2] - when[1] != 18) begin
                bad++; $display("FAIL b2b_spacing got=%0d,%0d,%0d want=17,35,53", when[0], when[1], when[2]);
            end
        end
        total++; if (nb != 16 * 3 + 16) begin bad++; $display("FAIL b2b_busy_cycles got=%0d want=64", nb); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] res;
        logic        we;
        logic [3:0]  wa;
        int          lat;
        int          seen = 0;
        // Back-to-back left an op in flight; the reset below aborts it
        @(negedge clk);
        op = 2'b11; a = 16'h4321; b = 16'h0005; dst = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (busy !== 1'b1) begin
            // Previous op still draining: wait for a fresh accept
            for (int i = 0; i < 40 && busy !== 1'b0; i++) begin @(posedge clk); #1; end
            @(negedge clk); start = 1'b1;
            for (int i = 0; i < 40 && busy !== 1'b1; i++) begin @(posedge clk); #1; end
            start = 1'b0;
        end
        repeat (7) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0h want=0", busy); end
        total++; if (result !== 16'h0 || wr_addr !== 4'h0) begin bad++; $display("FAIL midreset_regs got=%0h/%0h want=0/0", result, wr_addr); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || wr_en === 1'b1) seen++;
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || wr_en === 1'b1 || busy === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midreset_activity got=%0d want=0", seen); end
        run_op(2'b11, 16'h4321, 16'h0005, 4'd2, res, lat, we, wa);
        total++; if (res !== ref_res(2'b11, 16'h4321, 16'h0005) || we !== 1'b1 || wa !== 4'd2) begin
            bad++; $display("FAIL after_reset_op got=%0h we=%0h wa=%0h want=%0h we=1 wa=2", res, we, wa, ref_res(2'b11, 16'h4321, 16'h0005));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
